// File: rtl/alu_bist_sequencer.sv
// -----------------------------------------------------------------------------
// alu_bist_sequencer
//
// Built-in self-test sequencer for the core's combinational ALU. While a run
// is active it drives AluOp/SrcA/SrcB from registered state. AluOp sweeps
// 0..LAST_OP. For each op it applies VECTORS operand pairs taken from two
// Galois LFSRs. Each cycle it folds the returned result and flags into a
// 32-bit MISR. At the end of the run the MISR value is presented on
// `signature` and compared against `expected_sig`.
//
// Optional feature (macro ALU_BIST_CORNER_EN):
//   The first four vectors of every op use fixed corner operand pairs. The
//   operand LFSRs hold during those vectors. Total run length is unchanged.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            begin a run (sampled only in IDLE)
//   busy             high while vectors are being applied
//   done             one-cycle pulse when the final vector has been absorbed
//   pass             registered (signature == expected_sig), valid from done
//   signature        final MISR value, held until the next start
//   expected_sig     golden signature
//   AluOp/SrcA/SrcB  registered stimulus to the ALU (zero outside RUN)
//   result, ZeroFlag, OverflowFlag, NegativeFlag, CarryFlag  ALU response
//   dbg_state        current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: start is a level sampled on a rising edge only while IDLE. The
// run begins on that edge, and start is ignored in every other state. There
// is no ready/ack; completion is reported by the single-cycle done pulse.
// -----------------------------------------------------------------------------
module alu_bist_sequencer #(
  parameter int unsigned VECTORS  = 256,
  parameter logic [3:0]  LAST_OP  = 4'd10,
  parameter logic [31:0] SEED_A   = 32'hACE1_2468,
  parameter logic [31:0] SEED_B   = 32'h1357_9BDF,
  parameter logic [31:0] SIG_INIT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  input  logic [31:0] expected_sig,
  output logic [3:0]  AluOp,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  input  logic [31:0] result,
  input  logic        ZeroFlag,
  input  logic        OverflowFlag,
  input  logic        NegativeFlag,
  input  logic        CarryFlag,
  output logic [1:0]  dbg_state
);

  localparam int VW = (VECTORS > 1) ? $clog2(VECTORS) : 1;
  localparam logic [VW-1:0] VEC_LAST = VW'(VECTORS - 1);

`ifdef ALU_BIST_CORNER_EN
  localparam bit CORNER_EN = 1'b1;
`else
  localparam bit CORNER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 32-bit Galois LFSR / MISR shift, taps 0x8020_0003.
  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // True for the fixed-pair vectors at the start of each op.
  function automatic logic is_corner(input logic [VW-1:0] v);
    return CORNER_EN && (32'(v) < 32'd4);
  endfunction

  // Fixed operand pairs {SrcA, SrcB}. They target zero, carry-out and
  // signed overflow in add/sub.
  function automatic logic [63:0] corner_pair(input logic [VW-1:0] v);
    case (32'(v))
      32'd0:   return {32'h0000_0000, 32'h0000_0000};
      32'd1:   return {32'hFFFF_FFFF, 32'h0000_0001};
      32'd2:   return {32'h7FFF_FFFF, 32'h0000_0001};
      default: return {32'h8000_0000, 32'hFFFF_FFFF};
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   lfsr_a_q, lfsr_a_d;
  logic [31:0]   lfsr_b_q, lfsr_b_d;
  logic [31:0]   sig_q, sig_d;
  logic [3:0]    op_q, op_d;
  logic [VW-1:0] vec_q, vec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [31:0]   signature_q, signature_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [31:0]   src_a_q, src_a_d;
  logic [31:0]   src_b_q, src_b_d;
  logic [31:0]   absorb;

  // Flags occupy the low nibble so that any flag error also perturbs the MISR.
  assign absorb = result ^ {28'd0, ZeroFlag, OverflowFlag, NegativeFlag, CarryFlag};

  always_comb begin
    state_d     = state_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    sig_d       = sig_q;
    op_d        = op_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    signature_d = signature_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          lfsr_a_d    = SEED_A;
          lfsr_b_d    = SEED_B;
          sig_d       = SIG_INIT;
          op_d        = 4'd0;
          vec_d       = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          signature_d = 32'd0;
        end
      end

      ST_RUN: begin
        sig_d = step(sig_q) ^ absorb;
        // Corner vectors do not consume LFSR states, so the pseudo-random
        // stream resumes exactly where it stopped.
        if (!is_corner(vec_q)) begin
          lfsr_a_d = step(lfsr_a_q);
          lfsr_b_d = step(lfsr_b_q);
        end
        if (vec_q == VEC_LAST) begin
          vec_d = '0;
          op_d  = op_q + 4'd1;
          if (op_q == LAST_OP) begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            signature_d = sig_d;
            pass_d      = (sig_d == expected_sig);
          end
        end else begin
          vec_d = vec_q + VW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        // Re-sample the golden value during the done cycle and hold the
        // result until the next start.
        pass_d  = (sig_q == expected_sig);
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Operand registers are loaded from the next-state view. The ALU then
    // sees each vector for a full cycle before it is absorbed.
    alu_op_d = 4'd0;
    src_a_d  = 32'd0;
    src_b_d  = 32'd0;
    if (state_d == ST_RUN) begin
      alu_op_d = op_d;
      if (is_corner(vec_d)) begin
        {src_a_d, src_b_d} = corner_pair(vec_d);
      end else begin
        src_a_d = lfsr_a_d;
        src_b_d = lfsr_b_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_a_q    <= 32'd0;
      lfsr_b_q    <= 32'd0;
      sig_q       <= 32'd0;
      op_q        <= 4'd0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      signature_q <= 32'd0;
      alu_op_q    <= 4'd0;
      src_a_q     <= 32'd0;
      src_b_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      sig_q       <= sig_d;
      op_q        <= op_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      signature_q <= signature_d;
      alu_op_q    <= alu_op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = signature_q;
  assign AluOp     = alu_op_q;
  assign SrcA      = src_a_q;
  assign SrcB      = src_b_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
module tb_alu_bist_sequencer;

  localparam int VECTORS = 256;
  localparam int NOPS    = 11;
  localparam int N       = VECTORS * NOPS;
  localparam logic [31:0] SEED_A   = 32'hACE1_2468;
  localparam logic [31:0] SEED_B   = 32'h1357_9BDF;
  localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;

`ifdef ALU_BIST_CORNER_EN
  localparam bit CORNER = 1'b1;
`else
  localparam bit CORNER = 1'b0;
`endif

  int vectors_applied = 0;
  int miscompares     = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- full-size DUT with a behavioural ALU ----------------
  logic        start, busy, done, pass;
  logic [31:0] signature, expected_sig;
  logic [3:0]  alu_op;
  logic [31:0] src_a, src_b, result;
  logic        zf, vf, nf, cf;
  logic [1:0]  dbg_state;
  logic        fault_on;
  logic [4:0]  fault_bit;
  logic [35:0] alu_out;

  alu_bist_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .expected_sig(expected_sig),
    .AluOp(alu_op), .SrcA(src_a), .SrcB(src_b), .result(result),
    .ZeroFlag(zf), .OverflowFlag(vf), .NegativeFlag(nf), .CarryFlag(cf),
    .dbg_state(dbg_state)
  );

  // ---------------- small DUT (1 vector, op 0) with stub ALU ----------------
  logic        s_start, s_busy, s_done, s_pass;
  logic [31:0] s_signature, s_expected, s_src_a, s_src_b, s_result;
  logic [3:0]  s_alu_op;
  logic        s_zf, s_vf, s_nf, s_cf;
  logic [1:0]  s_dbg_state;

  alu_bist_sequencer #(.VECTORS(1), .LAST_OP(4'd0)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done), .pass(s_pass),
    .signature(s_signature), .expected_sig(s_expected),
    .AluOp(s_alu_op), .SrcA(s_src_a), .SrcB(s_src_b), .result(s_result),
    .ZeroFlag(s_zf), .OverflowFlag(s_vf), .NegativeFlag(s_nf), .CarryFlag(s_cf),
    .dbg_state(s_dbg_state)
  );

  // ---------------- reference functions ----------------
  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Returns {Zero, Overflow, Negative, Carry, result[31:0]}.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic v, c;
    w = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = ~w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = {31'd0, $signed(a) < $signed(b)};
      4'd6:  r = a << b[4:0];
      4'd7:  r = a >> b[4:0];
      4'd8:  r = 32'($signed(a) >>> b[4:0]);
      4'd9:  r = ~(a | b);
      4'd10: r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return {r == 32'd0, v, r[31], c, r};
  endfunction

  function automatic logic [63:0] corner_pair(input int i);
    case (i)
      0:       return {32'h0000_0000, 32'h0000_0000};
      1:       return {32'hFFFF_FFFF, 32'h0000_0001};
      2:       return {32'h7FFF_FFFF, 32'h0000_0001};
      default: return {32'h8000_0000, 32'hFFFF_FFFF};
    endcase
  endfunction

  // Golden signature of a fault-free full run.
  function automatic logic [31:0] golden_sig();
    logic [31:0] la, lb, a, b, sig;
    logic [35:0] r;
    la = SEED_A; lb = SEED_B; sig = SIG_INIT;
    for (int k = 0; k < N; k++) begin
      if (CORNER && (k % VECTORS) < 4) begin
        {a, b} = corner_pair(k % VECTORS);
      end else begin
        a = la; b = lb; la = step(la); lb = step(lb);
      end
      r = alu_f(4'(k / VECTORS), a, b);
      sig = step(sig) ^ (r[31:0] ^ {28'd0, r[35:32]});
    end
    return sig;
  endfunction

  assign alu_out = alu_f(alu_op, src_a, src_b);
  assign result  = alu_out[31:0] ^ (fault_on ? (32'd1 << fault_bit) : 32'd0);
  assign {zf, vf, nf, cf} = alu_out[35:32];

  logic [31:0] gold;

  // ---------------- driver / checker tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors_applied++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 32'd0 ||
        alu_op !== 4'd0 || src_a !== 32'd0 || src_b !== 32'd0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_main: busy=%b done=%b pass=%b sig=%h op=%h a=%h b=%h st=%0d, want all zero",
               busy, done, pass, signature, alu_op, src_a, src_b, dbg_state);
    end
    vectors_applied++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_pass !== 1'b0 || s_signature !== 32'd0 ||
        s_alu_op !== 4'd0 || s_src_a !== 32'd0 || s_src_b !== 32'd0 || s_dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_small: busy=%b done=%b pass=%b sig=%h st=%0d, want all zero",
               s_busy, s_done, s_pass, s_signature, s_dbg_state);
    end
    rst = 1'b0;
  endtask

  // Small config: one vector, stub ALU.
  task automatic test_small(input logic zero_flag, input logic [31:0] exp_sig, input logic exp_pass,
                            input string name);
    s_result = 32'd0; s_zf = zero_flag; s_vf = 1'b0; s_nf = 1'b0; s_cf = 1'b0;
    s_expected = 32'hFFDF_FFFC;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    vectors_applied++;
    if (s_busy !== 1'b1 || s_done !== 1'b0 || s_alu_op !== 4'd0 || s_src_a !== SEED_A || s_src_b !== SEED_B) begin
      miscompares++;
      $display("FAIL %s_vec: busy=%b done=%b op=%h a=%h b=%h, want busy=1 done=0 op=0 a=%h b=%h",
               name, s_busy, s_done, s_alu_op, s_src_a, s_src_b, SEED_A, SEED_B);
    end
    @(posedge clk); #1;
    vectors_applied++;
    if (s_busy !== 1'b0 || s_done !== 1'b1 || s_signature !== exp_sig || s_pass !== exp_pass ||
        s_src_a !== 32'd0) begin
      miscompares++;
      $display("FAIL %s_done: busy=%b done=%b sig=%h pass=%b a=%h, want busy=0 done=1 sig=%h pass=%b a=0",
               name, s_busy, s_done, s_signature, s_pass, s_src_a, exp_sig, exp_pass);
    end
    @(posedge clk); #1;
    vectors_applied++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_signature !== exp_sig || s_pass !== exp_pass || s_dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL %s_after: done=%b busy=%b sig=%h pass=%b st=%0d, want done=0 busy=0 sig=%h pass=%b st=0",
               name, s_done, s_busy, s_signature, s_pass, s_dbg_state, exp_sig, exp_pass);
    end
    s_zf = 1'b0;
  endtask

  // Full run on the main DUT. pulse_at >= 0 pulses start in RUN at that
  // vector and again in DONE; fault_idx >= 0 flips one result bit there.
  task automatic run_check(input int pulse_at, input int fault_idx, input string name,
                           output logic [31:0] sig_out);
    logic [31:0] la, lb, ea, eb;
    logic exp_pass;
    exp_pass = (fault_idx < 0);
    expected_sig = gold;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    la = SEED_A; lb = SEED_B;
    for (int k = 0; k < N; k++) begin
      if (CORNER && (k % VECTORS) < 4) begin
        {ea, eb} = corner_pair(k % VECTORS);
      end else begin
        ea = la; eb = lb; la = step(la); lb = step(lb);
      end
      vectors_applied++;
      if (busy !== 1'b1 || done !== 1'b0 || alu_op !== 4'(k / VECTORS) || src_a !== ea || src_b !== eb) begin
        miscompares++;
        $display("FAIL %s_vec%0d: busy=%b done=%b op=%h a=%h b=%h, want busy=1 done=0 op=%h a=%h b=%h",
                 name, k, busy, done, alu_op, src_a, src_b, 4'(k / VECTORS), ea, eb);
      end
      fault_on = (k == fault_idx);
      start    = (k == pulse_at);
      @(posedge clk); #1;
    end
    fault_on = 1'b0;
    start = 1'b0;
    vectors_applied++;
    if (busy !== 1'b0 || done !== 1'b1 || alu_op !== 4'd0 || src_a !== 32'd0 || src_b !== 32'd0) begin
      miscompares++;
      $display("FAIL %s_end: busy=%b done=%b op=%h a=%h b=%h, want busy=0 done=1 zero operands",
               name, busy, done, alu_op, src_a, src_b);
    end
    vectors_applied++;
    if (fault_idx < 0) begin
      if (signature !== gold || pass !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_sig: sig=%h pass=%b, want sig=%h pass=1", name, signature, pass, gold);
      end
    end else begin
      if (signature === gold || pass !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_sig: sig=%h pass=%b, want sig!=%h pass=0", name, signature, pass, gold);
      end
    end
    sig_out = signature;
    start = (pulse_at >= 0);
    @(posedge clk); #1;
    start = 1'b0;
    vectors_applied++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0 || signature !== sig_out || pass !== exp_pass) begin
      miscompares++;
      $display("FAIL %s_idle: done=%b busy=%b st=%0d sig=%h pass=%b, want done=0 busy=0 st=0 sig=%h pass=%b",
               name, done, busy, dbg_state, signature, pass, sig_out, exp_pass);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    test_reset();
    run_check(-1, -1, "after_reset", s);
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1, s2;
    run_check(-1, -1, "b2b_first", s1);
    run_check(-1, -1, "b2b_second", s2);
    vectors_applied++;
    if (s1 !== s2) begin
      miscompares++;
      $display("FAIL b2b_equal: first=%h second=%h, want identical", s1, s2);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] s;
    run_check(1000, -1, "start_ignored", s);
  endtask

  task automatic test_fault();
    logic [31:0] s;
    fault_bit = 5'd7;
    run_check(-1, 1500, "fault", s);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expected_sig = 32'd0; fault_on = 1'b0; fault_bit = 5'd0;
    s_start = 1'b0; s_expected = 32'd0; s_result = 32'd0;
    s_zf = 1'b0; s_vf = 1'b0; s_nf = 1'b0; s_cf = 1'b0;
    gold = golden_sig();
    test_reset();
    test_small(1'b0, 32'hFFDF_FFFC, 1'b1, "small_clean");
    test_small(1'b1, 32'hFFDF_FFF4, 1'b0, "small_zero");
    test_reset_mid_run();
    test_back_to_back();
    test_start_ignored();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
